// File: rtl/fxp_divider.sv
// Signed fixed-point restoring divider with saturation, divide-by-zero and overflow flags.
// Optional macro FXP_DIV_ROUND_EN: one extra guard iteration, round half away from zero.
module fxp_divider #(
    parameter int WIDTH = 24,
    parameter int FBITS = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] o_val
);
    localparam int ITER = WIDTH + FBITS;
    localparam int QW   = ITER + 1;
`ifdef FXP_DIV_ROUND_EN
    localparam int NITER = ITER + 1;
`else
    localparam int NITER = ITER;
`endif
    localparam int CW = $clog2(ITER + 2);
    localparam logic [CW-1:0]    CNT_LAST = CW'(NITER);
    localparam logic [QW-1:0]    LIM      = QW'(1) << (WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT_POS  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, INIT, CALC, FINISH} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [QW-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0] o_val_q, o_val_d;
    logic             valid_q, valid_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic             accept;
    logic             b_zero;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [QW-1:0]    mag;
    logic             mag_ovf;
    logic [WIDTH-1:0] res;

    // Start is blocked during the done cycle so a held request cannot restart early.
    assign accept = (state_q == IDLE) && start && !done_q;
    assign b_zero = (b == '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !b_zero) state_d = INIT;
            INIT:    state_d = CALC;
            CALC:    if (cnt_q == CNT_LAST) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        abs_a    = a_q[WIDTH-1] ? -a_q : a_q;
        abs_b    = b_q[WIDTH-1] ? -b_q : b_q;
        // Numerator sits MSB-aligned in quo_q; its top bit feeds the remainder each step.
        trial    = {rem_q, quo_q[QW-1]};
        trial_ge = (trial >= {1'b0, abs_b});
`ifdef FXP_DIV_ROUND_EN
        mag      = {1'b0, quo_q[QW-1:1]} + QW'(quo_q[0]);
`else
        mag      = {1'b0, quo_q[QW-2:0]};
`endif
        mag_ovf  = sign_q ? (mag > LIM) : (mag >= LIM);
        res      = sign_q ? -mag[WIDTH-1:0] : mag[WIDTH-1:0];

        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        o_val_d = o_val_q;
        valid_d = valid_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    valid_d = 1'b0;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    if (b_zero) begin
                        dbz_d   = 1'b1;
                        done_d  = 1'b1;
                        o_val_d = a[WIDTH-1] ? SAT_NEG : SAT_POS;
                    end
                end
            end
            INIT: begin
                rem_d = '0;
                quo_d = QW'(abs_a) << (FBITS + 1);
                cnt_d = '0;
            end
            CALC: begin
                if (cnt_q != CNT_LAST) begin
                    rem_d = trial_ge ? WIDTH'(trial - {1'b0, abs_b}) : trial[WIDTH-1:0];
                    quo_d = {quo_q[QW-2:0], trial_ge};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                ovf_d   = mag_ovf;
                valid_d = !mag_ovf;
                o_val_d = mag_ovf ? (sign_q ? SAT_NEG : SAT_POS) : res;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            o_val_q <= '0;
            valid_q <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            o_val_q <= o_val_d;
            valid_q <= valid_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign done  = done_q;
    assign valid = valid_q;
    assign dbz   = dbz_q;
    assign ovf   = ovf_q;
    assign o_val = o_val_q;

endmodule

// File: tb/tb_fxp_divider.sv
// Self-checking bench for fxp_divider: directed vector table, randomized operands against
// an arithmetic reference model, and hand sequences for reset, divide-by-zero and held start.
module tb_fxp_divider;
    localparam int WIDTH = 24;
    localparam int FBITS = 8;
    localparam int ITER  = WIDTH + FBITS;
`ifdef FXP_DIV_ROUND_EN
    localparam bit ROUND = 1'b1;
    localparam int LAT   = ITER + 4;
`else
    localparam bit ROUND = 1'b0;
    localparam int LAT   = ITER + 3;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, valid, dbz, ovf;
    logic [WIDTH-1:0] o_val;

    int errors = 0;
    int checks = 0;

    fxp_divider #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .CLK(CLK), .RST(RST), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .valid(valid), .dbz(dbz), .ovf(ovf), .o_val(o_val)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] val;
        logic             valid;
        logic             dbz;
        logic             ovf;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                input logic [WIDTH-1:0] v, input logic vl,
                                input logic dz, input logic ov);
        vec_t r;
        r.a = ta; r.b = tb; r.val = v; r.valid = vl; r.dbz = dz; r.ovf = ov;
        return r;
    endfunction

    // Reference: exact integer quotient of |a|*2^FBITS / |b|, then sign and saturation.
    function automatic vec_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
        vec_t   r;
        longint sa, sb, ma, mb, num, q, rm, lim, v;
        bit     neg;
        sa  = longint'($signed(ta));
        sb  = longint'($signed(tb));
        lim = 64'sd1 << (WIDTH - 1);
        r.a = ta; r.b = tb;
        if (sb == 0) begin
            r.dbz = 1'b1; r.valid = 1'b0; r.ovf = 1'b0;
            v = (sa < 0) ? -lim : lim - 1;
        end else begin
            ma  = (sa < 0) ? -sa : sa;
            mb  = (sb < 0) ? -sb : sb;
            num = ma << FBITS;
            q   = num / mb;
            rm  = num % mb;
            if (ROUND && (2 * rm >= mb)) q = q + 1;
            neg = (sa < 0) != (sb < 0);
            r.dbz = 1'b0;
            if (!neg && q > lim - 1) begin
                v = lim - 1; r.ovf = 1'b1; r.valid = 1'b0;
            end else if (neg && q > lim) begin
                v = -lim; r.ovf = 1'b1; r.valid = 1'b0;
            end else begin
                v = neg ? -q : q; r.ovf = 1'b0; r.valid = 1'b1;
            end
        end
        r.val = v[WIDTH-1:0];
        return r;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < LAT + 20) begin
            @(posedge CLK); #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string name, input vec_t v);
        int lat;
        bit busy_ok;
        busy_ok = 1'b1;
        @(negedge CLK);
        if (done) @(negedge CLK);
        a = v.a; b = v.b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < LAT + 20) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge CLK); #1;
            lat++;
        end
        chk({name, ".latency"}, lat, (v.b == '0) ? 0 : LAT);
        chk({name, ".busy_during"}, busy_ok, 1);
        chk({name, ".busy_at_done"}, busy, 0);
        chk({name, ".o_val"}, o_val, v.val);
        chk({name, ".valid"}, valid, v.valid);
        chk({name, ".dbz"}, dbz, v.dbz);
        chk({name, ".ovf"}, ovf, v.ovf);
        @(posedge CLK); #1;
        chk({name, ".done_width"}, done, 0);
    endtask

    initial begin
        int   lat;
        int   seen;
        vec_t rv;
        logic [WIDTH-1:0] ra, rb;

        RST = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.valid", valid, 0);
        chk("reset.dbz", dbz, 0);
        chk("reset.ovf", ovf, 0);
        chk("reset.o_val", o_val, 0);
        @(negedge CLK); RST = 1'b0;

        tbl[0]  = mk(24'h000A00, 24'h000400, 24'h000280, 1, 0, 0);
        tbl[1]  = mk(24'h000001, 24'h000200, ROUND ? 24'h000001 : 24'h000000, 1, 0, 0);
        tbl[2]  = mk(24'hFFFFFF, 24'h000200, ROUND ? 24'hFFFFFF : 24'h000000, 1, 0, 0);
        tbl[3]  = mk(24'h7FFF00, 24'h000080, 24'h7FFFFF, 0, 0, 1);
        tbl[4]  = mk(24'h800000, 24'hFFFF00, 24'h7FFFFF, 0, 0, 1);
        tbl[5]  = mk(24'h800000, 24'h000100, 24'h800000, 1, 0, 0);
        tbl[6]  = mk(24'hFFF600, 24'h000000, 24'h800000, 0, 1, 0);
        tbl[7]  = mk(24'h000500, 24'h000000, 24'h7FFFFF, 0, 1, 0);
        tbl[8]  = mk(24'h000000, 24'h000000, 24'h7FFFFF, 0, 1, 0);
        tbl[9]  = mk(24'h000000, 24'h000300, 24'h000000, 1, 0, 0);
        tbl[10] = mk(24'h000000, 24'hFFFD00, 24'h000000, 1, 0, 0);
        tbl[11] = mk(24'hFFF600, 24'h000400, 24'hFFFD80, 1, 0, 0);
        tbl[12] = mk(24'h000100, 24'h000300, 24'h000055, 1, 0, 0);
        tbl[13] = mk(24'h000200, 24'h000300, ROUND ? 24'h0000AB : 24'h0000AA, 1, 0, 0);
        tbl[14] = mk(24'h7FFFFF, 24'h000100, 24'h7FFFFF, 1, 0, 0);
        tbl[15] = mk(24'h800000, 24'h000200, 24'hC00000, 1, 0, 0);
        tbl[16] = mk(24'h800000, 24'h000080, 24'h800000, 0, 0, 1);

        for (int i = 0; i < 17; i++) begin
            run_and_check($sformatf("vec%0d", i), tbl[i]);
        end

        for (int k = 0; k < 40; k++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom) >> $urandom_range(0, 22);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if (k % 10 == 3) rb = '0;
            if (k % 7 == 5) ra = ra >> $urandom_range(8, 23);
            rv = model(ra, rb);
            run_and_check($sformatf("rnd%0d", k), rv);
        end

        // Divide-by-zero, then a held start: ignored in the done cycle, taken on the next.
        @(negedge CLK);
        a = 24'hFFF600; b = '0; start = 1'b1;
        @(posedge CLK); #1;
        chk("dbz_seq.done", done, 1);
        chk("dbz_seq.dbz", dbz, 1);
        chk("dbz_seq.o_val", o_val, 24'h800000);
        chk("dbz_seq.valid", valid, 0);
        a = 24'h000A00; b = 24'h000400;
        @(posedge CLK); #1;
        chk("dbz_seq.ignored_in_done", busy, 0);
        @(posedge CLK); #1;
        chk("dbz_seq.accepted_after", busy, 1);
        start = 1'b0;
        wait_done(lat);
        chk("dbz_seq.latency2", lat, LAT);
        chk("dbz_seq.o_val2", o_val, 24'h000280);
        chk("dbz_seq.dbz_cleared", dbz, 0);
        chk("dbz_seq.valid2", valid, 1);

        // Outputs hold steady while idle.
        repeat (5) @(posedge CLK);
        #1;
        chk("hold.o_val", o_val, 24'h000280);
        chk("hold.valid", valid, 1);

        // Reset in the middle of CALC aborts without a completion pulse.
        @(negedge CLK);
        a = 24'h7FFF00; b = 24'h000300; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (11) @(posedge CLK);
        #1;
        chk("abort.busy_before", busy, 1);
        RST = 1'b1;
        #1;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.valid", valid, 0);
        chk("abort.dbz", dbz, 0);
        chk("abort.ovf", ovf, 0);
        chk("abort.o_val", o_val, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK); RST = 1'b0;
        seen = 0;
        repeat (LAT + 5) begin
            @(posedge CLK); #1;
            if (done) seen++;
        end
        chk("abort.no_done", seen, 0);

        // Start presented with the reset release is taken on the first edge; held high throughout.
        @(negedge CLK); RST = 1'b1;
        @(negedge CLK); RST = 1'b0;
        a = 24'hFFF600; b = 24'h000400; start = 1'b1;
        @(posedge CLK); #1;
        chk("post_reset.accepted", busy, 1);
        wait_done(lat);
        chk("held.latency", lat, LAT);
        chk("held.o_val", o_val, 24'hFFFD80);
        chk("held.valid", valid, 1);
        a = 24'h000200; b = 24'h000300;
        @(posedge CLK); #1;
        chk("held.ignored_in_done", busy, 0);
        chk("held.done_width", done, 0);
        @(posedge CLK); #1;
        chk("held.accepted_after", busy, 1);
        chk("held.valid_cleared", valid, 0);
        chk("held.o_val_kept", o_val, 24'hFFFD80);
        start = 1'b0;
        wait_done(lat);
        chk("held.latency2", lat, LAT);
        chk("held.o_val2", o_val, ROUND ? 24'h0000AB : 24'h0000AA);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
